// File: rtl/mapache64_pkg.sv
// mapache64 shared types and VRAM map.
// Used by the foreground renderer and obm_dma.
package mapache64;

  typedef logic [11:0] vram_address_t;
  typedef logic [7:0]  data_t;

  localparam vram_address_t PMF_BASE = 12'h000;
  localparam vram_address_t OBM_BASE = 12'h800;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RUN,
    DRAIN
  } dma_state_t;

endpackage

// File: rtl/obm_dma.sv
// obm_dma: copies one work-RAM page into OBM
// during vertical blank, one byte per cycle.
module obm_dma #(
  parameter int NUM_OBJECTS      = 64,
  parameter int BYTES_PER_OBJECT = 4,
  parameter mapache64::vram_address_t OBM_BASE =
    mapache64::OBM_BASE
) (
  input  logic                     cpu_clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [7:0]               src_page_i,
  input  logic                     vblank_i,
  output logic [15:0]              ram_address_o,
  output logic                     ram_ren_o,
  input  mapache64::data_t         ram_data_i,
  output mapache64::vram_address_t vram_address_o,
  output mapache64::data_t         data_o,
  output logic                     wen_o,
  output logic                     SELECT_obm_o,
  output logic                     busy_o,
  output logic                     done_o
);

  import mapache64::*;

  localparam int L  = NUM_OBJECTS * BYTES_PER_OBJECT;
  localparam int IW = $clog2(L) + 1;

  localparam logic [IW-1:0] LAST = IW'(L - 1);
  localparam logic [IW-1:0] LEN  = IW'(L);

  dma_state_t    state;
  logic [7:0]    page;
  logic [IW-1:0] idx;
  logic [IW-1:0] widx;
  logic          s1_valid;

  // Sequencer plus the two-stage read->write pipe.
  // ram_ren_o is stage 0, s1_valid stage 1,
  // wen_o stage 2; in-flight bytes drain even
  // after vblank drops.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      state          <= IDLE;
      page           <= '0;
      idx            <= '0;
      widx           <= '0;
      s1_valid       <= 1'b0;
      ram_ren_o      <= 1'b0;
      ram_address_o  <= '0;
      vram_address_o <= '0;
      data_o         <= '0;
      wen_o          <= 1'b0;
      SELECT_obm_o   <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      wen_o        <= s1_valid;
      SELECT_obm_o <= s1_valid;
      data_o       <= s1_valid ? ram_data_i : '0;
      vram_address_o <= s1_valid
        ? OBM_BASE + 12'(widx) : '0;
      if (s1_valid) widx <= widx + 1'b1;

      s1_valid      <= ram_ren_o;
      ram_ren_o     <= 1'b0;
      ram_address_o <= '0;
      done_o        <= 1'b0;

      unique case (state)
        IDLE: begin
          // a start in the done cycle is dropped
          if (start_i && !done_o) begin
            page   <= src_page_i;
            busy_o <= 1'b1;
            widx   <= '0;
            if (vblank_i) begin
              ram_ren_o     <= 1'b1;
              ram_address_o <= {src_page_i, 8'h00};
              idx           <= IW'(1);
              state <= (L == 1) ? DRAIN : RUN;
            end else begin
              idx   <= '0;
              state <= WAIT;
            end
          end
        end
        WAIT, RUN: begin
          if (vblank_i) begin
            ram_ren_o     <= 1'b1;
            ram_address_o <= {page, 8'(idx)};
            idx           <= idx + 1'b1;
            state <= (idx == LAST) ? DRAIN : RUN;
          end else begin
            state <= WAIT;
          end
        end
        DRAIN: begin
          // wen_o with widx==L is the final byte
          if (wen_o && widx == LEN) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obm_dma.sv
// tb_obm_dma: directed bench with an in-order
// transfer model checked every cycle.
module tb_obm_dma;

  logic        cpu_clk;
  logic        rst;
  logic        start_i;
  logic [7:0]  src_page_i;
  logic        vblank_i;
  logic [15:0] ram_address_o;
  logic        ram_ren_o;
  logic [7:0]  ram_data_i;
  logic [11:0] vram_address_o;
  logic [7:0]  data_o;
  logic        wen_o;
  logic        SELECT_obm_o;
  logic        busy_o;
  logic        done_o;

  obm_dma dut (
    .cpu_clk        (cpu_clk),
    .rst            (rst),
    .start_i        (start_i),
    .src_page_i     (src_page_i),
    .vblank_i       (vblank_i),
    .ram_address_o  (ram_address_o),
    .ram_ren_o      (ram_ren_o),
    .ram_data_i     (ram_data_i),
    .vram_address_o (vram_address_o),
    .data_o         (data_o),
    .wen_o          (wen_o),
    .SELECT_obm_o   (SELECT_obm_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  localparam int L = 256;

  logic [7:0] mem [0:65535];

  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  // synchronous work RAM, data valid next cycle
  always @(posedge cpu_clk) begin
    if (ram_ren_o) ram_data_i <= mem[ram_address_o];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // model state
  logic       rst_prev = 1'b1;
  logic       vb_prev = 1'b0;
  logic       ren_p1 = 1'b0;
  logic       ren_p2 = 1'b0;
  logic       wen_p1 = 1'b0;
  logic       mbusy = 1'b0;
  logic [7:0] page_m = 8'h00;
  int rd_next = 0;
  int wr_next = 0;
  int t0 = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int first_ren = -1;
  int first_wen = -1;
  logic [15:0] last_rd = '0;
  logic [11:0] last_wr = '0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic compare();
    if (rst_prev) begin
      chk("rst_outputs",
          {23'd0, ram_ren_o, ram_address_o,
           vram_address_o, data_o, wen_o,
           SELECT_obm_o, busy_o, done_o}, 64'd0);
      mbusy   = 1'b0;
      rd_next = 0;
      wr_next = 0;
      ren_p1  = 1'b0;
      ren_p2  = 1'b0;
      wen_p1  = 1'b0;
    end else begin
      chk("wen_latency", wen_o, ren_p2);
      chk("sel_eq_wen", SELECT_obm_o, wen_o);
      if (wen_o) begin
        chk("wr_range", wr_next < L, 1);
        chk("wr_addr", vram_address_o,
            12'h800 + 12'(wr_next));
        chk("wr_data", data_o,
            mem[{page_m, 8'(wr_next)}]);
        if (wr_next == 0) first_wen = cyc;
        last_wr = vram_address_o;
        wr_next++;
      end else begin
        chk("idle_vaddr", vram_address_o, 0);
        chk("idle_data", data_o, 0);
      end
      if (ram_ren_o) begin
        chk("rd_busy", mbusy, 1);
        chk("rd_vblank", vb_prev, 1);
        chk("rd_range", rd_next < L, 1);
        chk("rd_addr", ram_address_o,
            {page_m, 8'(rd_next)});
        if (rd_next == 0) first_ren = cyc;
        last_rd = ram_address_o;
        rd_next++;
      end
      if (done_o) begin
        chk("done_all_written", wr_next, L);
        chk("done_after_wen", wen_p1, 1);
        done_cnt++;
        done_cyc = cyc;
        mbusy = 1'b0;
      end
      chk("busy", busy_o, mbusy);
      if (start_i && !mbusy && !done_o && !rst) begin
        mbusy   = 1'b1;
        page_m  = src_page_i;
        rd_next = 0;
        wr_next = 0;
        t0      = cyc + 1;
      end
      ren_p2 = ren_p1;
      ren_p1 = ram_ren_o;
      wen_p1 = wen_o;
    end
    vb_prev  = vblank_i;
    rst_prev = rst;
  endtask

  task automatic tick();
    @(negedge cpu_clk);
    compare();
    @(posedge cpu_clk);
    cyc++;
    #1;
  endtask

  task automatic clear_stats();
    done_cnt  = 0;
    done_cyc  = -1;
    first_ren = -1;
    first_wen = -1;
  endtask

  task automatic start_xfer(input logic [7:0] pg);
    clear_stats();
    src_page_i = pg;
    start_i    = 1'b1;
    tick();
    start_i    = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > 0) break;
      tick();
    end
    chk("done_seen", done_cnt, 1);
  endtask

  task automatic wait_rd(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (rd_next >= n) break;
      tick();
    end
    chk("rd_reached", rd_next >= n, 1);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    for (int k = 0; k < 256; k++) begin
      mem[16'h0200 + k] = 8'(k) ^ 8'h5A;
      mem[16'h0300 + k] = 8'(k) ^ 8'hA5;
    end
    rst = 1'b1;
    start_i = 1'b0;
    src_page_i = 8'h00;
    vblank_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // full copy, plus a start in the done cycle
    vblank_i = 1'b1;
    start_xfer(8'h02);
    while (cyc < t0 + 258) tick();
    src_page_i = 8'h03;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (5) tick();
    chk("full_first_ren", first_ren - t0, 0);
    chk("full_first_wen", first_wen - t0, 2);
    chk("full_done_cyc", done_cyc - t0, 258);
    chk("full_writes", wr_next, 256);
    chk("full_done_cnt", done_cnt, 1);
    chk("full_last_rd", last_rd, 16'h02FF);
    chk("full_last_wr", last_wr, 12'h8FF);
    chk("done_cycle_start_ignored", busy_o, 0);

    // deferred start
    vblank_i = 1'b0;
    start_xfer(8'h02);
    repeat (40) tick();
    chk("defer_no_rd", rd_next, 0);
    chk("defer_no_wr", wr_next, 0);
    chk("defer_busy", busy_o, 1);
    vblank_i = 1'b1;
    begin
      int vset;
      vset = cyc;
      wait_done(400);
      chk("defer_first_ren", first_ren - vset, 1);
      chk("defer_first_wen", first_wen - vset, 3);
    end
    chk("defer_writes", wr_next, 256);
    tick();

    // pause after byte 100 issued
    start_xfer(8'h02);
    wait_rd(101, 300);
    vblank_i = 1'b0;
    repeat (500) tick();
    chk("pause_rd", rd_next, 102);
    chk("pause_wr", wr_next, 102);
    chk("pause_no_done", done_cnt, 0);
    vblank_i = 1'b1;
    wait_done(400);
    chk("pause_writes", wr_next, 256);
    chk("pause_last_wr", last_wr, 12'h8FF);
    tick();

    // start while busy
    start_xfer(8'h02);
    wait_rd(50, 300);
    src_page_i = 8'h03;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done(400);
    repeat (5) tick();
    chk("busy_start_done_cnt", done_cnt, 1);
    chk("busy_start_last_rd", last_rd, 16'h02FF);
    chk("busy_start_writes", wr_next, 256);

    // reset mid-transfer, then a clean copy
    start_xfer(8'h02);
    wait_rd(120, 300);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("rst_no_done", done_cnt, 0);
    chk("rst_no_wr", wr_next, 0);
    chk("rst_idle_busy", busy_o, 0);
    start_xfer(8'h02);
    wait_done(400);
    chk("rst_copy_first_ren", first_ren - t0, 0);
    chk("rst_copy_done_cyc", done_cyc - t0, 258);
    chk("rst_copy_writes", wr_next, 256);
    tick();

    // vblank toggling every cycle
    start_xfer(8'h02);
    for (int i = 0; i < 1200; i++) begin
      if (done_cnt > 0) break;
      vblank_i = ~vblank_i;
      tick();
    end
    chk("toggle_done", done_cnt, 1);
    chk("toggle_rd", rd_next, 256);
    chk("toggle_wr", wr_next, 256);
    chk("toggle_last_wr", last_wr, 12'h8FF);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
